// File: rtl/spn_pkg.sv
// Shared encodings for the SPN host driver and its paired cipher unit (CU).
package spn_pkg;

    localparam int TIMEOUT_CYCLES_DEF = 8;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_ENC  = 2'b01,
        OP_DEC  = 2'b10,
        OP_ILL  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_TIMEOUT = 2'b00,
        ST_ENC_OK  = 2'b01,
        ST_DEC_OK  = 2'b10,
        ST_ERROR   = 2'b11
    } status_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    function automatic logic op_legal(input logic [1:0] op);
        return (op == OP_ENC) || (op == OP_DEC);
    endfunction

endpackage

// File: rtl/spn_host_driver.sv
// Host-side request/response driver for the SPN cipher unit: issues one
// operation at a time, waits for the CU with a timeout, and holds the result.
module spn_host_driver
    import spn_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [15:0] req_data,
    input  logic        key_load,
    input  logic [31:0] key_in,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [1:0]  rsp_status,
    output logic [1:0]  cu_opcode,
    output logic [15:0] cu_data_in,
    output logic [31:0] cu_secret_key,
    input  logic [15:0] cu_data_out,
    input  logic [1:0]  cu_valid,
    output logic [15:0] done_count,
    output logic [7:0]  err_count
);

    state_t      state;
    logic [1:0]  op_q;
    logic [15:0] data_q;
    logic [31:0] key_q;
    logic [15:0] rsp_data_q;
    logic [1:0]  status_q;
    logic [7:0]  tmo_cnt;
    logic [1:0]  opcode_q;

    assign req_ready     = (state == S_IDLE);
    assign rsp_valid     = (state == S_RESP);
    assign rsp_data      = rsp_data_q;
    assign rsp_status    = status_q;
    assign cu_opcode     = opcode_q;
    assign cu_data_in    = data_q;
    assign cu_secret_key = key_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            op_q       <= OP_NONE;
            data_q     <= '0;
            key_q      <= '0;
            rsp_data_q <= '0;
            status_q   <= ST_TIMEOUT;
            tmo_cnt    <= '0;
            opcode_q   <= OP_NONE;
            done_count <= '0;
            err_count  <= '0;
        end else begin
            // The opcode is a one-cycle pulse, only ever raised on entry to ISSUE.
            opcode_q <= OP_NONE;
            unique case (state)
                S_IDLE: begin
                    if (key_load)
                        key_q <= key_in;
                    if (req_valid) begin
                        op_q   <= req_op;
                        data_q <= req_data;
                        if (op_legal(req_op)) begin
                            state    <= S_ISSUE;
                            opcode_q <= req_op;
                        end else begin
                            state      <= S_RESP;
                            status_q   <= ST_ERROR;
                            rsp_data_q <= '0;
                        end
                    end
                end
                S_ISSUE: begin
                    state   <= S_WAIT;
                    tmo_cnt <= '0;
                end
                S_WAIT: begin
                    if (cu_valid == OP_NONE) begin
                        // Counter value N means N+1 idle WAIT cycles so far.
                        if (tmo_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                            state      <= S_RESP;
                            status_q   <= ST_TIMEOUT;
                            rsp_data_q <= '0;
                        end else begin
                            tmo_cnt <= tmo_cnt + 8'd1;
                        end
                    end else begin
                        state <= S_RESP;
                        if (cu_valid == op_q) begin
                            status_q   <= cu_valid;
                            rsp_data_q <= cu_data_out;
                        end else begin
                            status_q   <= ST_ERROR;
                            rsp_data_q <= '0;
                        end
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                        if (status_q == ST_ENC_OK || status_q == ST_DEC_OK)
                            done_count <= done_count + 16'd1;
                        else if (err_count != 8'hFF)
                            err_count <= err_count + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spn_host_driver.sv
// Bench for spn_host_driver: stub CU, vector table, scoreboard and corner sequences.
module tb_spn_host_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [15:0] req_data = '0;
    logic        key_load = 1'b0;
    logic [31:0] key_in = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_status;
    logic [1:0]  cu_opcode;
    logic [15:0] cu_data_in;
    logic [31:0] cu_secret_key;
    logic [15:0] cu_data_out;
    logic [1:0]  cu_valid;
    logic [15:0] done_count;
    logic [7:0]  err_count;

    spn_host_driver #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
        .key_load(key_load), .key_in(key_in),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_status(rsp_status),
        .cu_opcode(cu_opcode), .cu_data_in(cu_data_in), .cu_secret_key(cu_secret_key),
        .cu_data_out(cu_data_out), .cu_valid(cu_valid),
        .done_count(done_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Toy cipher for the stub CU: XOR with both key halves, so it is its own inverse.
    function automatic logic [15:0] cu_func(input logic [15:0] d, input logic [31:0] k);
        return d ^ k[15:0] ^ k[31:16];
    endfunction

    // Stub CU: answers in the second cycle after the opcode pulse.
    // Modes: 0 conforming, 1 silent, 2 error status, 3 wrong-op status.
    int          cu_mode = 0;
    logic [1:0]  glitch = 2'b00;
    logic        pend;
    logic [1:0]  pend_op, stub_valid;
    logic [15:0] pend_data, stub_data;
    logic [31:0] pend_key;
    assign cu_valid    = stub_valid | glitch;
    assign cu_data_out = stub_data;

    always @(posedge clk) begin
        if (reset) begin
            pend       <= 1'b0;
            stub_valid <= 2'b00;
            stub_data  <= '0;
        end else begin
            stub_valid <= 2'b00;
            if (pend) begin
                case (cu_mode)
                    0: stub_valid <= pend_op;
                    1: stub_valid <= 2'b00;
                    2: stub_valid <= 2'b11;
                    default: stub_valid <= (pend_op == 2'b01) ? 2'b10 : 2'b01;
                endcase
                stub_data <= cu_func(pend_data, pend_key);
            end
            pend <= (cu_opcode != 2'b00);
            if (cu_opcode != 2'b00) begin
                pend_op   <= cu_opcode;
                pend_data <= cu_data_in;
                pend_key  <= cu_secret_key;
            end
        end
    end

    int         n_pulses = 0;
    logic [1:0] last_op = 2'b00;
    always @(negedge clk) begin
        if (cu_opcode != 2'b00) begin
            n_pulses <= n_pulses + 1;
            last_op  <= cu_opcode;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [15:0] data;
        logic        kl;
        logic [31:0] key;
        int          mode;
        int          hold;
        bit          poke;
        logic [1:0]  exp_status;
        logic [15:0] exp_data;
        int          exp_lat;
    } vec_t;

    logic [17:0] sb_q[$];
    logic [31:0] cur_key = '0;
    int          exp_done = 0;
    int          exp_err = 0;

    task automatic run_vec(input vec_t v);
        int          a, p0;
        bit          got;
        logic [15:0] d0;
        logic [1:0]  s0;
        logic [17:0] exp;
        @(negedge clk);
        cu_mode   = v.mode;
        key_load  = v.kl;
        key_in    = v.key;
        req_op    = v.op;
        req_data  = v.data;
        req_valid = 1'b1;
        if (v.kl) cur_key = v.key;
        check("req_ready_idle", req_ready, 1);
        sb_q.push_back({v.exp_status, v.exp_data});
        p0 = n_pulses;
        @(negedge clk);
        req_valid = 1'b0;
        key_load  = 1'b0;
        a   = cyc;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (rsp_valid) begin
                got = 1'b1;
            end else begin
                if (v.poke && cyc == a + 1) begin
                    key_load = 1'b1;
                    key_in   = 32'h0000_0000;
                end else begin
                    key_load = 1'b0;
                end
                @(negedge clk);
            end
        end
        key_load = 1'b0;
        check("rsp_arrived", got, 1);
        check("latency", cyc - a + 1, v.exp_lat);
        d0 = rsp_data;
        s0 = rsp_status;
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_data", rsp_data, d0);
            check("hold_status", rsp_status, s0);
            check("hold_req_ready", req_ready, 0);
        end
        if (sb_q.size() == 0) begin
            check("sb_underflow", 0, 1);
        end else begin
            exp = sb_q.pop_front();
            check("rsp_status", rsp_status, exp[17:16]);
            check("rsp_data", rsp_data, exp[15:0]);
            if (exp[17:16] == 2'b01 || exp[17:16] == 2'b10) exp_done++;
            else if (exp_err < 255) exp_err++;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_rsp_valid", rsp_valid, 0);
        check("post_req_ready", req_ready, 1);
        check("opcode_pulses", n_pulses - p0, (v.op == 2'b01 || v.op == 2'b10) ? 1 : 0);
        if (v.op == 2'b01 || v.op == 2'b10) check("opcode_value", last_op, v.op);
        check("key_reg", cu_secret_key, cur_key);
        check("done_count", done_count, exp_done[15:0]);
        check("err_count", err_count, exp_err[7:0]);
    endtask

    vec_t vecs[10];
    vec_t ill;

    initial begin
        vecs[0] = '{2'b01, 16'h1234, 1'b1, 32'hDEADBEEF, 0, 0, 1'b0, 2'b01, 16'h7276, 4};
        vecs[1] = '{2'b10, 16'h7276, 1'b0, 32'h0, 0, 0, 1'b0, 2'b10, 16'h1234, 4};
        vecs[2] = '{2'b11, 16'h9999, 1'b0, 32'h0, 0, 0, 1'b0, 2'b11, 16'h0000, 1};
        vecs[3] = '{2'b00, 16'h4321, 1'b0, 32'h0, 0, 0, 1'b0, 2'b11, 16'h0000, 1};
        vecs[4] = '{2'b01, 16'hA5A5, 1'b0, 32'h0, 1, 0, 1'b0, 2'b00, 16'h0000, 10};
        vecs[5] = '{2'b01, 16'h0F0F, 1'b0, 32'h0, 2, 0, 1'b0, 2'b11, 16'h0000, 4};
        vecs[6] = '{2'b10, 16'h5555, 1'b0, 32'h0, 3, 0, 1'b0, 2'b11, 16'h0000, 4};
        vecs[7] = '{2'b01, 16'hFFFF, 1'b0, 32'h0, 0, 10, 1'b0, 2'b01, cu_func(16'hFFFF, 32'hDEADBEEF), 4};
        vecs[8] = '{2'b01, 16'h0001, 1'b1, 32'h12345678, 0, 0, 1'b0, 2'b01, cu_func(16'h0001, 32'h12345678), 4};
        vecs[9] = '{2'b01, 16'h1234, 1'b1, 32'hDEADBEEF, 0, 2, 1'b1, 2'b01, 16'h7276, 4};
        ill     = '{2'b11, 16'hBEEF, 1'b0, 32'h0, 0, 0, 1'b0, 2'b11, 16'h0000, 1};

        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_status", rsp_status, 0);
        check("rst_cu_opcode", cu_opcode, 0);
        check("rst_cu_data_in", cu_data_in, 0);
        check("rst_cu_key", cu_secret_key, 0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_done", done_count, 0);
        check("rst_err", err_count, 0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // CU status while idle must not start a response.
        glitch = 2'b01;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("glitch_rsp_valid", rsp_valid, 0);
            check("glitch_req_ready", req_ready, 1);
        end
        glitch = 2'b00;

        for (int i = 0; i < 256; i++) run_vec(ill);
        check("err_saturated", err_count, 8'hFF);

        // Reset while waiting on the CU abandons the transaction.
        @(negedge clk);
        cu_mode   = 0;
        key_load  = 1'b1;
        key_in    = 32'hDEADBEEF;
        req_op    = 2'b01;
        req_data  = 16'h4444;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        key_load  = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_req_ready", req_ready, 1);
        check("mid_rst_done", done_count, 0);
        check("mid_rst_err", err_count, 0);
        check("mid_rst_key", cu_secret_key, 0);
        check("mid_rst_opcode", cu_opcode, 0);
        cur_key  = '0;
        exp_done = 0;
        exp_err  = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abandoned_no_rsp", rsp_valid, 0);
        end
        run_vec(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
